// File: rtl/rv32_pkg.sv
// Shared RV32I definitions used by the write-back stage.
package rv32_pkg;

  // Write-back source select, encoded the way the MEM stage drives wb_src.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IO  = 2'b10,
    WB_PC4 = 2'b11
  } wb_src_t;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

  // Halt FSM states
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} halt_st_t;

  // Register-file write request as driven onto the write port / forwarding bus
  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_wr_t;

endpackage

// File: rtl/rv32_load_align.sv
// Load data alignment: picks the addressed byte/half out of a raw word and extends it.
module rv32_load_align
  import rv32_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension by funct3; unknown funct3 yields zero
  always_comb begin
    byte_sel = raw[8*off +: 8];
    half_sel = raw[16*off[1] +: 16];
    data     = 32'h0;
    case (f3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      F3_LW:   data = raw;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32_wb_top.sv
// RV32I write-back stage: WB mux, register-file write gating, retire counter, EBREAK halt.
module rv32_wb_top
  import rv32_pkg::*;
#(
  parameter int HALT_ON_EBREAK = 1,
  parameter int CNT_W          = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      iw_in,
  input  logic [31:0]      alu_in,
  input  logic [4:0]       wb_reg_in,
  input  logic             wb_enable_in,
  input  logic [1:0]       wb_src_in,
  input  logic [31:0]      mem_rdata_in,
  input  logic [31:0]      io_rdata_in,
  output logic             regf_wen,
  output logic [4:0]       regf_wreg,
  output logic [31:0]      regf_wdata,
  output logic             df_wb_enable,
  output logic [4:0]       df_wb_reg,
  output logic [31:0]      df_wb_data,
  output logic [CNT_W-1:0] retire_count,
  output logic             halted
);

  halt_st_t         st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      raw, ld_data, wb_val;
  logic             retire;
  wb_wr_t           wr;

  rv32_load_align u_align (
    .raw  (raw),
    .off  (alu_in[1:0]),
    .f3   (iw_in[14:12]),
    .data (ld_data)
  );

  // Load source and write-back value select
  always_comb begin
    raw    = (wb_src_t'(wb_src_in) == WB_IO) ? io_rdata_in : mem_rdata_in;
    wb_val = alu_in;
    case (wb_src_t'(wb_src_in))
      WB_ALU:  wb_val = alu_in;
      WB_MEM,
      WB_IO:   wb_val = ld_data;
      WB_PC4:  wb_val = pc_in + 32'd4;
      default: wb_val = alu_in;
    endcase
  end

  // Write gating: x0 never written, nothing written while halted or in reset
  always_comb begin
    wr      = '0;
    if (!reset) begin
      wr.en   = wb_enable_in & (wb_reg_in != 5'd0) & ~halted;
      wr.rd   = wb_reg_in;
      wr.data = wb_val;
    end
  end

  assign regf_wen     = wr.en;
  assign regf_wreg    = wr.rd;
  assign regf_wdata   = wr.data;
  assign df_wb_enable = wr.en;
  assign df_wb_reg    = wr.rd;
  assign df_wb_data   = wr.data;

  // Retire counter next state; bubbles do not count, wraps naturally
  always_comb begin
    retire = (iw_in != 32'h0) & ~halted & ~reset;
    cnt_d  = cnt_q;
    if (retire) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retire_count = cnt_q;

  // Halt FSM state register; reset also leaves HALT
  always_ff @(posedge clk) begin
    if (reset) st_q <= ST_RUN;
    else       st_q <= st_d;
  end

  // Halt FSM next state: EBREAK retires this cycle, halt shows next cycle
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_RUN:  if ((HALT_ON_EBREAK != 0) && (iw_in == EBREAK_IW) && !reset) st_d = ST_HALT;
      ST_HALT: st_d = ST_HALT;
      default: st_d = ST_RUN;
    endcase
  end

  // Halt FSM output
  always_comb begin
    halted = (st_q == ST_HALT);
  end

endmodule
